// File: rtl/icache_pkg.sv
// Shared constants for the set-associative instruction cache.
//   S_IDLE / S_REFILL : controller state encoding
//   DEF_*             : default geometry used by i_cache_assoc and i_cache_lru
package icache_pkg;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  localparam int DEF_WAYS         = 2;
  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_INDEX_WIDTH  = 5;
  localparam int DEF_SELECT_WIDTH = 4;
  localparam int DEF_DATA_WIDTH   = 32;

  // Width of a way number; one bit even for a direct-mapped cache.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/i_cache_lru.sv
// True-LRU replacement state for i_cache_assoc.
// Ports:
//   clk, rst            clock, async active-low reset (clears all ages)
//   clr_i               synchronous clear of all ages (flush)
//   upd_en_i            update ages of set upd_idx_i for way upd_way_i
//   upd_fill_i          1 = update is a fill, 0 = update is a hit
//   vic_idx_i           set being refilled
//   vic_valid_i         valid bits of that set
//   victim_o            lowest invalid way, else the way with the oldest age
module i_cache_lru
  import icache_pkg::*;
#(
  parameter  int WAYS        = DEF_WAYS,
  parameter  int INDEX_WIDTH = DEF_INDEX_WIDTH,
  localparam int WAY_W       = way_bits(WAYS),
  localparam int SETS        = 2 ** INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   upd_en_i,
  input  logic                   upd_fill_i,
  input  logic [INDEX_WIDTH-1:0] upd_idx_i,
  input  logic [WAY_W-1:0]       upd_way_i,
  input  logic [INDEX_WIDTH-1:0] vic_idx_i,
  input  logic [WAYS-1:0]        vic_valid_i,
  output logic [WAY_W-1:0]       victim_o
);

  if (WAYS == 1) begin : g_dm
    assign victim_o = '0;
    logic unused_lru;
    assign unused_lru = ^{clk, rst, clr_i, upd_en_i, upd_fill_i, upd_idx_i,
                          upd_way_i, vic_idx_i, vic_valid_i};
  end else begin : g_lru
    localparam int              AGE_W   = $clog2(WAYS);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

    logic [AGE_W-1:0] age_q [SETS][WAYS];
    logic [AGE_W-1:0] row_d [WAYS];
    logic [AGE_W-1:0] acc_age;
    logic             vic_found;

    // A fill only ever lands on an invalid way or on the oldest way, so
    // "all others age by one, saturating" equals the hit rule for the oldest
    // way, and keeps valid ways at distinct ages 0..k-1 while the set fills.
    always_comb begin
      acc_age = age_q[upd_idx_i][upd_way_i];
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way_i)
          row_d[w] = '0;
        else if (upd_fill_i)
          row_d[w] = (age_q[upd_idx_i][w] == AGE_MAX) ? AGE_MAX
                                                      : age_q[upd_idx_i][w] + 1'b1;
        else
          row_d[w] = (age_q[upd_idx_i][w] < acc_age) ? age_q[upd_idx_i][w] + 1'b1
                                                     : age_q[upd_idx_i][w];
      end
    end

    always_comb begin
      victim_o  = '0;
      vic_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (!vic_found && !vic_valid_i[w]) begin
          victim_o  = WAY_W'(w);
          vic_found = 1'b1;
        end
      end
      if (!vic_found) begin
        for (int w = 0; w < WAYS; w++)
          if (age_q[vic_idx_i][w] == AGE_MAX) victim_o = WAY_W'(w);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end else if (clr_i) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end else if (upd_en_i) begin
        for (int w = 0; w < WAYS; w++) age_q[upd_idx_i][w] <= row_d[w];
      end
    end
  end

endmodule

// File: rtl/i_cache_assoc.sv
// Blocking set-associative instruction cache with single-line refill.
// Hits return the word combinationally; a miss stalls, reads the whole line
// from memory and replays as a hit the cycle after mem_done_i.
// Ports:
//   clk, rst                       clock, async active-low reset
//   core_req_i, core_addr_i        fetch request / byte address
//   core_data_o, core_stallreq_o   fetched word / stall request
//   mem_read_o, mem_addr_o         line read request (level) / line address
//   mem_data_i, mem_done_i         refill line (word 0 in LSBs) / done pulse
//   flush_i                        invalidate all lines (ICACHE_FLUSH_EN only)
// Build option: define ICACHE_FLUSH_EN to add flush_i and its logic.
module i_cache_assoc
  import icache_pkg::*;
#(
  parameter  int WAYS         = DEF_WAYS,
  parameter  int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter  int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter  int SELECT_WIDTH = DEF_SELECT_WIDTH,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - SELECT_WIDTH,
  localparam int WORDS        = 2 ** (SELECT_WIDTH - 2),
  localparam int BENCH_WIDTH  = DATA_WIDTH * WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_req_i,
  input  logic [ADDR_WIDTH-1:0]  core_addr_i,
  output logic [DATA_WIDTH-1:0]  core_data_o,
  output logic                   core_stallreq_o,
  output logic                   mem_read_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [BENCH_WIDTH-1:0] mem_data_i,
  input  logic                   mem_done_i
`ifdef ICACHE_FLUSH_EN
 ,input  logic                   flush_i
`endif
);

  localparam int SETS   = 2 ** INDEX_WIDTH;
  localparam int WORD_W = SELECT_WIDTH - 2;
  localparam int WAY_W  = way_bits(WAYS);

  logic [TAG_WIDTH-1:0]   tag_mem  [WAYS][SETS];
  logic [BENCH_WIDTH-1:0] data_mem [WAYS][SETS];
  logic [WAYS-1:0]        valid_q  [SETS];

  logic [0:0]            state_q, state_d;
  logic                  mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [TAG_WIDTH-1:0]   req_tag, fill_tag;
  logic [INDEX_WIDTH-1:0] req_idx, fill_idx, lru_idx;
  logic [WORD_W-1:0]      req_word;
  logic                   hit, stall, fill_we, clr_all, lru_en, flush_go;
  logic [WAY_W-1:0]       hit_way, victim, lru_way;
  logic [DATA_WIDTH-1:0]  hit_word, data;
  logic                   unused_lo;

  assign req_tag   = core_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx   = core_addr_i[SELECT_WIDTH +: INDEX_WIDTH];
  assign req_word  = core_addr_i[2 +: WORD_W];
  assign unused_lo = ^core_addr_i[1:0];
  // The registered line address doubles as the latched miss address.
  assign fill_tag  = mem_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign fill_idx  = mem_addr_q[SELECT_WIDTH +: INDEX_WIDTH];

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int i = 0; i < WORDS; i++)
      if (req_word == WORD_W'(i)) hit_word = data_mem[hit_way][req_idx][i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ICACHE_FLUSH_EN
  // A flush seen during REFILL waits until the controller is back in IDLE.
  logic flush_pend_q, flush_pend_d;
  assign flush_go = flush_i | flush_pend_q;

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (state_q == S_REFILL) flush_pend_d = flush_pend_q | flush_i;
    else                     flush_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flush_pend_q <= 1'b0;
    else      flush_pend_q <= flush_pend_d;
  end
`else
  assign flush_go = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    stall      = 1'b0;
    data       = '0;
    fill_we    = 1'b0;
    clr_all    = 1'b0;
    lru_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_go) begin
          clr_all = 1'b1;
          stall   = core_req_i;
        end else if (core_req_i) begin
          if (hit) begin
            data   = hit_word;
            lru_en = 1'b1;
          end else begin
            stall      = 1'b1;
            mem_read_d = 1'b1;
            mem_addr_d = {core_addr_i[ADDR_WIDTH-1:SELECT_WIDTH], {SELECT_WIDTH{1'b0}}};
            state_d    = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        stall = 1'b1;
        if (mem_done_i) begin
          fill_we    = 1'b1;
          lru_en     = 1'b1;
          mem_read_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, independent of core_req_i.
  assign core_stallreq_o = rst & stall;
  assign core_data_o     = rst ? data : '0;
  assign mem_read_o      = mem_read_q;
  assign mem_addr_o      = mem_addr_q;

  assign lru_idx = (state_q == S_REFILL) ? fill_idx : req_idx;
  assign lru_way = (state_q == S_REFILL) ? victim : hit_way;

  i_cache_lru #(.WAYS(WAYS), .INDEX_WIDTH(INDEX_WIDTH)) u_lru (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_all),
    .upd_en_i   (lru_en),
    .upd_fill_i (state_q == S_REFILL),
    .upd_idx_i  (lru_idx),
    .upd_way_i  (lru_way),
    .vic_idx_i  (fill_idx),
    .vic_valid_i(valid_q[fill_idx]),
    .victim_o   (victim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      if (clr_all)      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      else if (fill_we) valid_q[fill_idx][victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[victim][fill_idx]  <= fill_tag;
      data_mem[victim][fill_idx] <= mem_data_i;
    end
  end

endmodule
